// File: rtl/multicycle_cu.sv
// ---------------------------------------------------------------------------
// multicycle_cu -- multicycle RV32I control FSM
//
// Sits between the instruction-register decode fields and the datapath
// muxes / write enables. Handles R/I-type ALU ops, LUI, loads/stores (with
// an optional memory wait-state handshake and timeout), JAL/JALR and the
// full conditional branch set. Faults (illegal instruction, memory timeout)
// park the FSM in TRAP and stay visible on `fault` until reset.
//
// Parameters
//   SUPPORT_BRANCH     1: branch opcode legal, 0: decodes as illegal
//   SUPPORT_BYTE_HALF  0: only word load/store legal, 1: byte/half also legal
//   MEM_WAIT_EN        1: honour mem_ready, 0: treat mem_ready as always 1
//   MEM_TIMEOUT        max cycles in MEM_RD / MEM_WR before a timeout fault
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode/funct3/funct7 instruction fields from the IR
//   zf                  ALU zero flag
//   mem_ready           data memory completed the current access
//   ALU_OP, rs2_imm_s   ALU opcode and operand-B select (0=rs2, 1=imm)
//   w_data_s            write-back select (ALU / imm / mem / PC+4)
//   pc_s                next-PC select (PC+4 / pc0+imm / ALU&~1)
//   Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write  enables
//   fault               00 none, 01 illegal instruction, 10 memory timeout
//   state               current FSM state (debug)
//
// All outputs are registered and computed from the next state, so each
// output pattern is valid for exactly the cycles spent in its state.
// ---------------------------------------------------------------------------
module multicycle_cu #(
    parameter int SUPPORT_BRANCH    = 1,
    parameter int SUPPORT_BYTE_HALF = 0,
    parameter int MEM_WAIT_EN       = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zf,
    input  logic       mem_ready,
    output logic [3:0] ALU_OP,
    output logic       rs2_imm_s,
    output logic [1:0] w_data_s,
    output logic [1:0] pc_s,
    output logic       Reg_Write,
    output logic       IR_Write,
    output logic       PC_Write,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic [1:0] fault,
    output logic [4:0] state
);

    typedef enum logic [4:0] {
        S_IDLE     = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_EX_R     = 5'd3,
        S_EX_I     = 5'd4,
        S_WB_ALU   = 5'd5,
        S_WB_LUI   = 5'd6,
        S_MEM_ADDR = 5'd7,
        S_MEM_RD   = 5'd8,
        S_MEM_WB   = 5'd9,
        S_MEM_WR   = 5'd10,
        S_JAL      = 5'd11,
        S_JALR_EX  = 5'd12,
        S_JALR_WB  = 5'd13,
        S_BR_CMP   = 5'd14,
        S_BR_DONE  = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_next_s;
    logic [1:0]       fault_r, fault_next_s;
    logic             mem_ready_eff_s;

    logic [3:0] alu_op_r, alu_op_next_s;
    logic       rs2_imm_r, rs2_imm_next_s;
    logic [1:0] w_data_r, w_data_next_s;
    logic [1:0] pc_sel_r, pc_sel_next_s;
    logic       reg_wr_r, reg_wr_next_s;
    logic       ir_wr_r, ir_wr_next_s;
    logic       pc_wr_r, pc_wr_next_s;
    logic       mem_rd_r, mem_rd_next_s;
    logic       mem_wr_r, mem_wr_next_s;

    // R-type: funct7 all zero, or 0100000 only for sub / sra
    function automatic logic legal_r_f(input logic [2:0] f3, input logic [6:0] f7);
        logic ok_s;
        if (f7 == 7'b0000000) begin
            ok_s = 1'b1;
        end else if (f7 == 7'b0100000) begin
            ok_s = (f3 == 3'b000) || (f3 == 3'b101);
        end else begin
            ok_s = 1'b0;
        end
        return ok_s;
    endfunction

    // I-type: shift immediates carry funct7 in the upper immediate bits
    function automatic logic legal_i_f(input logic [2:0] f3, input logic [6:0] f7);
        logic ok_s;
        case (f3)
            3'b001:  ok_s = (f7 == 7'b0000000);
            3'b101:  ok_s = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            default: ok_s = 1'b1;
        endcase
        return ok_s;
    endfunction

    // Load/store width legality depends on byte/half support
    function automatic logic legal_ls_f(input logic is_load, input logic [2:0] f3);
        logic ok_s;
        if (SUPPORT_BYTE_HALF == 0) begin
            ok_s = (f3 == 3'b010);
        end else if (is_load) begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok_s = 1'b1;
                default:                                 ok_s = 1'b0;
            endcase
        end else begin
            ok_s = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        end
        return ok_s;
    endfunction

    // Branch taken decision from the comparison result seen on zf
    function automatic logic br_taken_f(input logic [2:0] f3, input logic z);
        logic t_s;
        case (f3)
            3'b000:  t_s = z;     // beq
            3'b001:  t_s = ~z;    // bne
            3'b100:  t_s = ~z;    // blt  (SLT result nonzero)
            3'b101:  t_s = z;     // bge
            3'b110:  t_s = ~z;    // bltu
            3'b111:  t_s = z;     // bgeu
            default: t_s = 1'b0;
        endcase
        return t_s;
    endfunction

    assign mem_ready_eff_s = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // Next-state, timeout counter and fault code
    always_comb begin
        state_next_s   = state_r;
        tmo_cnt_next_s = tmo_cnt_r;
        fault_next_s   = fault_r;
        case (state_r)
            S_IDLE:   state_next_s = S_FETCH;
            S_FETCH:  state_next_s = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R: begin
                        if (legal_r_f(funct3, funct7)) begin
                            state_next_s = S_EX_R;
                        end else begin
                            state_next_s = S_TRAP;
                            fault_next_s = FLT_ILLEGAL;
                        end
                    end
                    OP_I: begin
                        if (legal_i_f(funct3, funct7)) begin
                            state_next_s = S_EX_I;
                        end else begin
                            state_next_s = S_TRAP;
                            fault_next_s = FLT_ILLEGAL;
                        end
                    end
                    OP_LUI: state_next_s = S_WB_LUI;
                    OP_LOAD, OP_STORE: begin
                        if (legal_ls_f(opcode == OP_LOAD, funct3)) begin
                            state_next_s = S_MEM_ADDR;
                        end else begin
                            state_next_s = S_TRAP;
                            fault_next_s = FLT_ILLEGAL;
                        end
                    end
                    OP_JAL: state_next_s = S_JAL;
                    OP_JALR: begin
                        if (funct3 == 3'b000) begin
                            state_next_s = S_JALR_EX;
                        end else begin
                            state_next_s = S_TRAP;
                            fault_next_s = FLT_ILLEGAL;
                        end
                    end
                    OP_BR: begin
                        if (SUPPORT_BRANCH != 0) begin
                            state_next_s = S_BR_CMP;
                        end else begin
                            state_next_s = S_TRAP;
                            fault_next_s = FLT_ILLEGAL;
                        end
                    end
                    default: begin
                        state_next_s = S_TRAP;
                        fault_next_s = FLT_ILLEGAL;
                    end
                endcase
            end
            S_EX_R, S_EX_I: state_next_s = S_WB_ALU;
            S_WB_ALU, S_WB_LUI, S_MEM_WB, S_JAL, S_JALR_WB, S_BR_DONE:
                state_next_s = S_FETCH;
            S_MEM_ADDR: begin
                tmo_cnt_next_s = '0;
                if (opcode == OP_LOAD) begin
                    state_next_s = S_MEM_RD;
                end else begin
                    state_next_s = S_MEM_WR;
                end
            end
            S_MEM_RD, S_MEM_WR: begin
                // Completion wins over a timeout landing in the same cycle
                if (mem_ready_eff_s) begin
                    state_next_s = (state_r == S_MEM_RD) ? S_MEM_WB : S_FETCH;
                end else if (tmo_cnt_r == CNT_W'(MEM_TIMEOUT - 1)) begin
                    tmo_cnt_next_s = tmo_cnt_r + CNT_W'(1);
                    state_next_s   = S_TRAP;
                    fault_next_s   = FLT_TIMEOUT;
                end else begin
                    tmo_cnt_next_s = tmo_cnt_r + CNT_W'(1);
                end
            end
            S_JALR_EX: state_next_s = S_JALR_WB;
            S_BR_CMP: begin
                if (funct3[2:1] == 2'b01) begin
                    state_next_s = S_TRAP;
                    fault_next_s = FLT_ILLEGAL;
                end else begin
                    state_next_s = S_BR_DONE;
                end
            end
            S_TRAP:  state_next_s = S_TRAP;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Output values for the state being entered; selects hold unless set
    always_comb begin
        alu_op_next_s  = alu_op_r;
        rs2_imm_next_s = rs2_imm_r;
        w_data_next_s  = w_data_r;
        pc_sel_next_s  = pc_sel_r;
        reg_wr_next_s  = 1'b0;
        ir_wr_next_s   = 1'b0;
        pc_wr_next_s   = 1'b0;
        mem_rd_next_s  = 1'b0;
        mem_wr_next_s  = 1'b0;
        case (state_next_s)
            S_FETCH: begin
                ir_wr_next_s  = 1'b1;
                pc_wr_next_s  = 1'b1;
                pc_sel_next_s = 2'b00;
            end
            S_EX_R: begin
                alu_op_next_s  = {funct7[5], funct3};
                rs2_imm_next_s = 1'b0;
            end
            S_EX_I: begin
                rs2_imm_next_s = 1'b1;
                // Only the shift-right pair uses funct7[5] as an op bit
                if (funct3 == 3'b101) begin
                    alu_op_next_s = {funct7[5], funct3};
                end else begin
                    alu_op_next_s = {1'b0, funct3};
                end
            end
            S_WB_ALU: begin
                reg_wr_next_s = 1'b1;
                w_data_next_s = 2'b00;
            end
            S_WB_LUI: begin
                reg_wr_next_s = 1'b1;
                w_data_next_s = 2'b01;
            end
            S_MEM_ADDR, S_JALR_EX: begin
                alu_op_next_s  = 4'b0000;
                rs2_imm_next_s = 1'b1;
            end
            S_MEM_RD: mem_rd_next_s = 1'b1;
            S_MEM_WB: begin
                reg_wr_next_s = 1'b1;
                w_data_next_s = 2'b10;
            end
            S_MEM_WR: mem_wr_next_s = 1'b1;
            S_JAL: begin
                reg_wr_next_s = 1'b1;
                w_data_next_s = 2'b11;
                pc_wr_next_s  = 1'b1;
                pc_sel_next_s = 2'b01;
            end
            S_JALR_WB: begin
                reg_wr_next_s = 1'b1;
                w_data_next_s = 2'b11;
                pc_wr_next_s  = 1'b1;
                pc_sel_next_s = 2'b10;
            end
            S_BR_CMP: begin
                rs2_imm_next_s = 1'b0;
                case (funct3[2:1])
                    2'b00:   alu_op_next_s = 4'b1000;
                    2'b10:   alu_op_next_s = 4'b0010;
                    2'b11:   alu_op_next_s = 4'b0011;
                    default: alu_op_next_s = alu_op_r;
                endcase
            end
            S_BR_DONE: begin
                pc_sel_next_s = 2'b01;
                pc_wr_next_s  = br_taken_f(funct3, zf);
            end
            default: begin
                reg_wr_next_s = 1'b0;
            end
        endcase
    end

    // State, counter, fault and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            tmo_cnt_r <= '0;
            fault_r   <= FLT_NONE;
            alu_op_r  <= 4'b0000;
            rs2_imm_r <= 1'b0;
            w_data_r  <= 2'b00;
            pc_sel_r  <= 2'b00;
            reg_wr_r  <= 1'b0;
            ir_wr_r   <= 1'b0;
            pc_wr_r   <= 1'b0;
            mem_rd_r  <= 1'b0;
            mem_wr_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            tmo_cnt_r <= tmo_cnt_next_s;
            fault_r   <= fault_next_s;
            alu_op_r  <= alu_op_next_s;
            rs2_imm_r <= rs2_imm_next_s;
            w_data_r  <= w_data_next_s;
            pc_sel_r  <= pc_sel_next_s;
            reg_wr_r  <= reg_wr_next_s;
            ir_wr_r   <= ir_wr_next_s;
            pc_wr_r   <= pc_wr_next_s;
            mem_rd_r  <= mem_rd_next_s;
            mem_wr_r  <= mem_wr_next_s;
        end
    end

    assign ALU_OP    = alu_op_r;
    assign rs2_imm_s = rs2_imm_r;
    assign w_data_s  = w_data_r;
    assign pc_s      = pc_sel_r;
    assign Reg_Write = reg_wr_r;
    assign IR_Write  = ir_wr_r;
    assign PC_Write  = pc_wr_r;
    assign Mem_Read  = mem_rd_r;
    assign Mem_Write = mem_wr_r;
    assign fault     = fault_r;
    assign state     = state_r;

endmodule
